pattern_scan_ctrl: RTL and testbench
====================================

Name: pattern_scan_ctrl

Overview:
Sequencer for the serial bit-pattern detector datapath. Accepts a WIDTH-bit word on a start strobe and shifts it MSB-first, one bit per clock, through an embedded Mealy detector for the 4-bit PATTERN (overlapping matches allowed). Counts matches and reports the count with a one-cycle done pulse. Sits between a parallel producer (register file or host) and the serial detection logic, so software can scan whole words instead of hand-driving x each cycle.

Parameters:
WIDTH, 8, word length in bits shifted per scan (>= 4)
PATTERN, 4'b1101, bit pattern detected; PATTERN[3] is the first bit received
CNT_W, 4, width of the match counter; must satisfy 2**CNT_W - 1 >= WIDTH - 3 for exact counts, otherwise the count saturates

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request a scan; sampled only in IDLE
data_in  input  WIDTH  word to scan; latched on the accepted start
busy  output  1  1 from the cycle after start is accepted through the last SHIFT cycle
bit_out  output  1  bit currently presented to the detector (valid while busy)
match  output  1  Mealy output: 1 in the SHIFT cycle whose bit completes PATTERN
done  output  1  one-cycle pulse after the last bit is shifted
count  output  CNT_W  matches in the last completed scan; held until the next accepted start

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, bit index=0, detector history cleared, count=0. Outputs busy=0, bit_out=0, match=0, done=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if start=1 at posedge, then latch data_in, clear count, clear the detector history and bit index, and go to SHIFT. If start=0, stay in IDLE.
- SHIFT: bit_out = shreg[WIDTH-1]. At each posedge, shift left by 1, increment the bit index, and push bit_out into the detector history. After the cycle with index WIDTH-1, go to DONE. The state lasts exactly WIDTH cycles.
- DONE: done=1, busy=0 for one cycle, then go to IDLE unconditionally.
- Latency: start sampled at edge N; bits are presented in cycles N+1..N+WIDTH; done is high in cycle N+WIDTH+1. A new start is accepted no earlier than edge N+WIDTH+2.
- start while in SHIFT or DONE is ignored. It is not queued.
- data_in changes after acceptance have no effect.
- Detector (Mealy):
  - Keeps the previous 3 bits and a valid counter (0..3).
  - match = (valid==3) && ({hist[2:0], bit_out} == PATTERN) && state==SHIFT. This is purely combinational from the current bit.
  - History is cleared at each accepted start, so there are no matches across word boundaries.
- Counter: increments on posedge when match=1 and saturates at 2**CNT_W-1. The final value is visible in the DONE cycle and stays stable in IDLE.
- match is 0 outside SHIFT, and bit_out is 0 outside SHIFT.
- Reset asserted mid-scan aborts immediately: no done pulse, count=0, and the controller returns to IDLE on release.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the found/notfound constants for match.
- One sub-module, pattern_detect4. Inputs: clk, reset, clr, en, x. Output: y. Parameter: PATTERN. Holds the 3-bit history and valid counter.
- pattern_scan_ctrl holds the FSM, shift register, bit index and counter.

Test Plan:
- Basic scan, default parameters: start with data_in=8'b1101_1010. match pulses on the 4th and 7th SHIFT cycles; done pulses 9 cycles after the accepting edge; count=2.
- Overlap: data_in=8'b1101_1011. Matches occur on the 4th and 7th bits; count=2. With data_in=8'hFF, count=0 and match never asserts.
- No cross-word match: scan 8'b0000_0110, then scan 8'b1000_0000. Both counts are 0, because the history is cleared between scans.
- Start ignored while busy: pulse start with data_in=8'hFF during SHIFT of an 8'hDA scan. The first scan completes with count=2, and no second scan begins until start is reasserted in IDLE.
- Mid-scan reset: assert reset=0 during the 5th SHIFT cycle of 8'hDA. busy=0, count=0 and match=0 immediately, and done never pulses. After release, a scan of 8'hD0 yields count=1.
- Saturation: set WIDTH=16, CNT_W=2, data_in=16'hDDDD. Four match pulses occur (bits 4, 8, 12, 16); count saturates at 2'd3.

Source files
------------

// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared definitions for the serial pattern-scan sequencer and its detector.
package pattern_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } scan_state_e;

  localparam logic FOUND    = 1'b1;
  localparam logic NOTFOUND = 1'b0;

endpackage

// File: rtl/pattern_scan_ctrl_detect.sv
// Mealy detector for a 4-bit pattern on a serial stream; overlapping matches allowed.
module pattern_detect4
  import pattern_scan_ctrl_pkg::*;
#(
  parameter logic [3:0] PATTERN = 4'b1101
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic x,
  output logic y
);

  logic [2:0] hist_q;
  logic [1:0] valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q  <= '0;
      valid_q <= '0;
    end else if (clr) begin
      hist_q  <= '0;
      valid_q <= '0;
    end else if (en) begin
      hist_q <= {hist_q[1:0], x};
      if (valid_q != 2'd3) valid_q <= valid_q + 2'd1;
    end
  end

  // Match needs three real history bits so a cleared history never fakes a hit.
  assign y = (en && (valid_q == 2'd3) && ({hist_q, x} == PATTERN)) ? FOUND : NOTFOUND;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Shifts a latched word MSB-first through pattern_detect4 and counts matches per scan.
module pattern_scan_ctrl
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int         WIDTH   = 8,
  parameter logic [3:0] PATTERN = 4'b1101,
  parameter int         CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             bit_out,
  output logic             match,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  scan_state_e      state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             det_clr;
  logic             det_en;
  logic             det_y;

  assign det_clr = (state_q == ST_IDLE) && start;
  assign det_en  = (state_q == ST_SHIFT);
  assign bit_out = det_en ? shreg_q[WIDTH-1] : 1'b0;

  pattern_detect4 #(
    .PATTERN(PATTERN)
  ) u_detect (
    .clk  (clk),
    .reset(reset),
    .clr  (det_clr),
    .en   (det_en),
    .x    (bit_out),
    .y    (det_y)
  );

  assign match = det_y;
  assign busy  = busy_q;
  assign done  = done_q;
  assign count = cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            shreg_q <= data_in;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg_q <= shreg_q << 1;
          idx_q   <= idx_q + IDX_W'(1);
          if (det_y && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + CNT_W'(1);
          if (idx_q == LAST_IDX) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: 8-bit default instance plus a 16-bit saturating instance.
module tb_pattern_scan_ctrl;

  localparam logic [3:0] PAT = 4'b1101;

  logic        clk = 1'b0;
  logic        reset;
  logic        start8, start16;
  logic [7:0]  data8;
  logic [15:0] data16;
  logic        busy8, bit8, match8, done8;
  logic [3:0]  cnt8;
  logic        busy16, bit16, match16, done16;
  logic [1:0]  cnt16;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.WIDTH(8), .PATTERN(PAT), .CNT_W(4)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .data_in(data8),
    .busy(busy8), .bit_out(bit8), .match(match8), .done(done8), .count(cnt8)
  );

  pattern_scan_ctrl #(.WIDTH(16), .PATTERN(PAT), .CNT_W(2)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .data_in(data16),
    .busy(busy16), .bit_out(bit16), .match(match16), .done(done16), .count(cnt16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: bit presented in scan cycle t is word bit W-t; a match needs the
  // last four presented bits of this word to equal the pattern.
  function automatic logic e_match(input logic [15:0] w, input int W, input int t);
    logic [3:0] win;
    if (t < 4 || t > W) return 1'b0;
    win = {w[W-t+3], w[W-t+2], w[W-t+1], w[W-t]};
    return win == PAT;
  endfunction

  function automatic int e_count(input logic [15:0] w, input int W, input int cw, input int t);
    int n = 0;
    int sat = (1 << cw) - 1;
    for (int k = 4; k < t && k <= W; k++) if (e_match(w, W, k)) n++;
    return (n > sat) ? sat : n;
  endfunction

  // Scan position per instance: -1 idle, 1..W shifting, W+1 done.
  int t8 = -1, t16 = -1;
  int fin8 = 0, fin16 = 0;
  logic [15:0] w8 = '0, w16 = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      t8 <= -1; fin8 <= 0;
    end else if (t8 == -1) begin
      if (start8) begin t8 <= 1; w8 <= {8'h00, data8}; end
    end else if (t8 == 9) begin
      t8 <= -1; fin8 <= e_count(w8, 8, 4, 9);
    end else t8 <= t8 + 1;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      t16 <= -1; fin16 <= 0;
    end else if (t16 == -1) begin
      if (start16) begin t16 <= 1; w16 <= data16; end
    end else if (t16 == 17) begin
      t16 <= -1; fin16 <= e_count(w16, 16, 2, 17);
    end else t16 <= t16 + 1;
  end

  task automatic cmp_model(input string tag, input int t, input logic [15:0] w, input int W,
                           input int cw, input int fin, input logic b, input logic bo,
                           input logic m, input logic d, input logic [31:0] c);
    logic eb, ebo, em, ed;
    int ec;
    eb = 1'b0; ebo = 1'b0; em = 1'b0; ed = 1'b0; ec = fin;
    if (t >= 1 && t <= W) begin
      eb = 1'b1; ebo = w[W-t]; em = e_match(w, W, t); ec = e_count(w, W, cw, t);
    end else if (t == W + 1) begin
      ed = 1'b1; ec = e_count(w, W, cw, t);
    end
    chk({tag, "_busy"}, {31'd0, b}, {31'd0, eb});
    chk({tag, "_bit"}, {31'd0, bo}, {31'd0, ebo});
    chk({tag, "_match"}, {31'd0, m}, {31'd0, em});
    chk({tag, "_done"}, {31'd0, d}, {31'd0, ed});
    chk({tag, "_count"}, c, ec);
  endtask

  always @(negedge clk) begin
    cmp_model("m8", t8, w8, 8, 4, fin8, busy8, bit8, match8, done8, {28'd0, cnt8});
    cmp_model("m16", t16, w16, 16, 2, fin16, busy16, bit16, match16, done16, {30'd0, cnt16});
  end

  logic        sel16 = 1'b0;
  logic        obs_match, obs_done, obs_busy;
  logic [31:0] obs_cnt;

  always_comb begin
    obs_match = sel16 ? match16 : match8;
    obs_done  = sel16 ? done16 : done8;
    obs_busy  = sel16 ? busy16 : busy8;
    obs_cnt   = sel16 ? {30'd0, cnt16} : {28'd0, cnt8};
  end

  task automatic run_scan(input string nm, input logic s16, input logic [15:0] w, input int W,
                          input int poke_c, input int rst_c, input logic [31:0] exp_mask,
                          input int exp_done, input int exp_cnt);
    logic [31:0] mask;
    int dc;
    sel16 = s16;
    @(posedge clk); #1;
    if (s16) begin data16 = w; start16 = 1'b1; end
    else begin data8 = w[7:0]; start8 = 1'b1; end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    mask = '0; dc = 0;
    for (int c = 1; c <= W + 6; c++) begin
      @(negedge clk);
      if (obs_match) mask[c] = 1'b1;
      if (obs_done && dc == 0) dc = c;
      if (c == poke_c) begin start8 = 1'b1; data8 = 8'hFF; end
      else if (c == poke_c + 1) start8 = 1'b0;
      if (c == rst_c) begin
        #2 reset = 1'b0;
        #1;
        chk({nm, "_rst_busy"}, {31'd0, busy8}, 32'd0);
        chk({nm, "_rst_cnt"}, {28'd0, cnt8}, 32'd0);
        chk({nm, "_rst_match"}, {31'd0, match8}, 32'd0);
      end
    end
    chk({nm, "_mask"}, mask, exp_mask);
    chk({nm, "_done_cycle"}, dc, exp_done);
    chk({nm, "_count"}, obs_cnt, exp_cnt);
    chk({nm, "_idle_busy"}, {31'd0, obs_busy}, 32'd0);
    if (rst_c > 0) begin
      @(negedge clk); #2 reset = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b0; start8 = 1'b0; start16 = 1'b0; data8 = '0; data16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy8}, 32'd0);
    chk("reset_bit", {31'd0, bit8}, 32'd0);
    chk("reset_match", {31'd0, match8}, 32'd0);
    chk("reset_done", {31'd0, done8}, 32'd0);
    chk("reset_count", {28'd0, cnt8}, 32'd0);
    chk("reset_count16", {30'd0, cnt16}, 32'd0);
    @(negedge clk); #2 reset = 1'b1;

    run_scan("basic_DA", 1'b0, 16'h00DA, 8, 0, 0, 32'h90, 9, 2);
    run_scan("overlap_DB", 1'b0, 16'h00DB, 8, 0, 0, 32'h90, 9, 2);
    run_scan("ones_FF", 1'b0, 16'h00FF, 8, 0, 0, 32'h0, 9, 0);
    run_scan("word_06", 1'b0, 16'h0006, 8, 0, 0, 32'h0, 9, 0);
    run_scan("word_80", 1'b0, 16'h0080, 8, 0, 0, 32'h0, 9, 0);
    run_scan("ignore_start", 1'b0, 16'h00DA, 8, 3, 0, 32'h90, 9, 2);
    run_scan("midscan_rst", 1'b0, 16'h00DA, 8, 0, 5, 32'h10, 0, 0);
    run_scan("after_rst_D0", 1'b0, 16'h00D0, 8, 0, 0, 32'h10, 9, 1);
    run_scan("sat_DDDD", 1'b1, 16'hDDDD, 16, 0, 0, 32'h11110, 17, 3);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
